// File: rtl/user_block_driver_if.sv
`default_nettype none
// =============================================================================
// Module      : user_block_driver_if
// Description : Host-buffer and user-block signal bundle for user_block_driver.
// Revision    : 1.0 - initial release
// =============================================================================
interface user_block_driver_if;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        go;
    logic        busy;
    logic        done;
    logic        err;
    logic        wr_rej;
    logic        start;
    logic [7:0]  data_in_addr;
    logic [31:0] data_in;
    logic [7:0]  data_out_addr;
    logic [31:0] data_out;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, go, data_in_addr, data_out_addr, data_out,
        output rd_data, busy, done, err, wr_rej, start, data_in
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, go, data_in_addr, data_out_addr, data_out,
        input  rd_data, busy, done, err, wr_rej, start, data_in
    );
endinterface
`default_nettype wire

// File: rtl/user_block_driver.sv
`default_nettype none
// =============================================================================
// Module      : user_block_driver
// Description : Buffers host data for a user block, launches one run per go and
//               captures its results; USER_BLOCK_DRIVER_TIMEOUT_EN adds a watchdog.
// Revision    : 1.0 - initial release
// =============================================================================
module user_block_driver #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FLAG_ADDR      = 9
) (
    input  wire logic         clk,
    input  wire logic         rst,
    user_block_driver_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [7:0] c_flag_addr = 8'(FLAG_ADDR);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_in_buf  [64];
    logic [31:0] r_res_buf [64];
    logic [31:0] r_rd_data;
    logic        r_wr_rej;
    logic        r_armed;
    logic        w_flag_hit;
    logic        w_complete;
    logic        w_timeout;
    logic        w_res_we;

    assign w_flag_hit = (r_state == S_RUN) && (bus.data_out_addr == c_flag_addr);
    // Completion needs a prior flag=0 in this run so a stale flag=1 cannot end it.
    assign w_complete = w_flag_hit && r_armed && bus.data_out[0];
    assign w_res_we   = !rst && (r_state == S_RUN) && (bus.data_out_addr[7:6] == 2'b00);

`ifdef USER_BLOCK_DRIVER_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_cnt_w-1:0] r_tmo_cnt;
    logic               r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_RUN) && (r_tmo_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && bus.go) begin
            r_err <= 1'b0;
        end else if (w_timeout && !w_complete) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.go) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_RUN;
            S_RUN:    if (w_complete || w_timeout) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_wr_rej  <= 1'b0;
            r_rd_data <= 32'h0;
        end else begin
            if (r_state == S_LAUNCH) begin
                r_armed <= 1'b0;
            end else if (w_flag_hit && !bus.data_out[0]) begin
                r_armed <= 1'b1;
            end
            r_wr_rej  <= bus.wr_en && (r_state != S_IDLE);
            r_rd_data <= r_res_buf[bus.rd_addr];
        end
    end

    // Buffer storage carries no reset; only the write enables are qualified by it.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_IDLE) && bus.wr_en) begin
            r_in_buf[bus.wr_addr] <= bus.wr_data;
        end
        if (w_res_we) begin
            r_res_buf[bus.data_out_addr[5:0]] <= bus.data_out;
        end
    end

    assign bus.data_in = (bus.data_in_addr[7:6] == 2'b00) ? r_in_buf[bus.data_in_addr[5:0]] : 32'h0;
    assign bus.start   = (r_state == S_LAUNCH);
    assign bus.done    = (r_state == S_FINISH);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.wr_rej  = r_wr_rej;
    assign bus.rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: doc/user_block_driver.md
USER_BLOCK_DRIVER -- requirements
Module: user_block_driver

Interface
REQ-001 The module SHALL take parameter TIMEOUT_CYCLES, default 4096, as the maximum RUN-state cycles before abort when the watchdog is compiled in.
REQ-002 The module SHALL take parameter FLAG_ADDR, default 9, as the user-side result word carrying the process-done flag in bit 0.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  host write strobe into the input buffer.
REQ-006 wr_addr  input  6  host input-buffer word index.
REQ-007 wr_data  input  32  host input-buffer write data.
REQ-008 rd_addr  input  6  host result-buffer word index.
REQ-009 rd_data  output  32  registered result-buffer read data.
REQ-010 go  input  1  single-cycle host request to launch one block run.
REQ-011 busy  output  1  high from go acceptance until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  sticky timeout indication, cleared by the next accepted go.
REQ-014 wr_rej  output  1  one-cycle pulse when a host write is rejected.
REQ-015 start  output  1  one-cycle launch pulse to the user functional block.
REQ-016 data_in_addr  input  8  word index requested by the user block.
REQ-017 data_in  output  32  input-buffer word served to the user block.
REQ-018 data_out_addr  input  8  result word index presented by the user block.
REQ-019 data_out  input  32  result word presented by the user block.

Function
REQ-020 The module SHALL hold a 64x32 input buffer and a 64x32 result buffer.
REQ-021 data_in SHALL equal in_buf[data_in_addr[5:0]] combinationally when data_in_addr < 64, else 32'h0.
REQ-022 FSM states SHALL be IDLE, LAUNCH, RUN, FINISH; IDLE->LAUNCH on go, LAUNCH->RUN unconditionally, RUN->FINISH on completion or timeout, FINISH->IDLE unconditionally.
REQ-023 start SHALL be high exactly during LAUNCH; done SHALL be high exactly during FINISH.
REQ-024 busy SHALL be high in LAUNCH, RUN, FINISH and low in IDLE.
REQ-025 go SHALL be ignored outside IDLE.
REQ-026 Host writes SHALL update in_buf only in IDLE; a write outside IDLE SHALL be dropped and pulse wr_rej the next cycle.
REQ-027 wr_en and go in the same IDLE cycle SHALL both take effect; the write lands before LAUNCH.
REQ-028 In RUN, each cycle with data_out_addr < 64 SHALL write data_out into res_buf[data_out_addr[5:0]]; addresses >= 64 SHALL be ignored.
REQ-029 An internal armed bit SHALL clear in LAUNCH and set in RUN when data_out_addr == FLAG_ADDR and data_out[0] == 0.
REQ-030 Completion SHALL occur when armed is already set and data_out_addr == FLAG_ADDR and data_out[0] == 1; that word is still captured.
REQ-031 rd_data SHALL equal res_buf[rd_addr] one cycle after rd_addr is presented, in any state; same-cycle capture and read SHALL return the old value.

Reset
REQ-032 With rst high at a clock edge: state IDLE; start, busy, done, err, wr_rej, armed, rd_data and the timeout counter 0.
REQ-033 Buffer contents SHALL NOT be reset.
REQ-034 Reset asserted in any state SHALL abort the run without a done pulse.

Configuration
REQ-035 Macro USER_BLOCK_DRIVER_TIMEOUT_EN SHALL compile in the watchdog.
REQ-036 With the macro defined, a counter SHALL clear in LAUNCH and increment each RUN cycle; reaching TIMEOUT_CYCLES-1 without completion SHALL go to FINISH and set err.
REQ-037 Without the macro, RUN SHALL persist until completion and err SHALL be constant 0.

Verification
REQ-038 Write in_buf[i]=i for i=0..63, go, model returns ~data_in for each word and then flag 0 followed by 1 -> start pulses once, done pulses once, rd_data at 5 = 32'hFFFFFFFA.
REQ-039 Model presents FLAG_ADDR with bit0=1 before any 0 -> no completion; a later 0 then 1 -> done.
REQ-040 wr_en with wr_addr=3, wr_data=32'hDEAD in RUN -> wr_rej pulse, in_buf[3] unchanged.
REQ-041 data_in_addr=8'h80 -> data_in=0; data_out_addr=8'h40 in RUN -> res_buf unchanged.
REQ-042 Macro defined, TIMEOUT_CYCLES=16, flag never set -> FINISH after 16 RUN cycles, done=1, err=1; next go clears err.
REQ-043 rst asserted in RUN -> next cycle busy=0, no done, a following go runs normally.
